// File: rtl/ann_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ann_layer_engine                                                |
// | Purpose  : Two-weighted-layer MLP engine (L0 -> L1 -> L2) on a single      |
// |            serial MAC, with streamed biases/weights and serial outputs.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ann_layer_engine #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int ACC_W   = 24,
    parameter int L0_SIZE = 16,
    parameter int L1_SIZE = 4,
    parameter int L2_SIZE = 1,
    parameter int SHIFT   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              act_wr_en,
    input  logic [$clog2(L0_SIZE)-1:0]        act_wr_addr,
    input  logic signed [DATA_W-1:0]          act_wr_data,
    output logic                              coef_req,
    input  logic                              coef_valid,
    input  logic signed [COEF_W-1:0]          coef_data,
    output logic                              busy,
    output logic                              out_valid,
    output logic [$clog2(L2_SIZE):0]          out_index,
    output logic signed [DATA_W-1:0]          out_data,
    output logic                              done_processing
);

    localparam int c_PROD_W  = DATA_W + COEF_W;
    localparam int c_MAX_IN  = (L0_SIZE > L1_SIZE) ? L0_SIZE : L1_SIZE;
    localparam int c_MAX_ND  = (L1_SIZE > L2_SIZE) ? L1_SIZE : L2_SIZE;
    localparam int c_IN_W    = (c_MAX_IN > 1) ? $clog2(c_MAX_IN) : 1;
    localparam int c_NODE_W  = (c_MAX_ND > 1) ? $clog2(c_MAX_ND) : 1;
    localparam int c_L0_AW   = $clog2(L0_SIZE);
    localparam int c_L1_AW   = (L1_SIZE > 1) ? $clog2(L1_SIZE) : 1;
    localparam int c_OI_W    = $clog2(L2_SIZE) + 1;

    localparam logic signed [ACC_W-1:0]  c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] c_OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_BIAS  = 3'd1;
    localparam logic [2:0] c_ST_MAC   = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]                r_state;
    logic                      r_layer2;
    logic [c_NODE_W-1:0]       r_node;
    logic [c_IN_W-1:0]         r_input;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_coef_req;
    logic                      r_busy;
    logic                      r_out_valid;
    logic [c_OI_W-1:0]         r_out_index;
    logic signed [DATA_W-1:0]  r_out_data;
    logic                      r_done;

    logic signed [DATA_W-1:0]  r_l0_buf [L0_SIZE];
    logic signed [DATA_W-1:0]  r_l1_buf [L1_SIZE];

    logic                          w_consume;
    logic                          w_last_input;
    logic                          w_last_node;
    logic signed [DATA_W-1:0]      w_act;
    logic signed [c_PROD_W-1:0]    w_prod;
    logic signed [ACC_W:0]         w_sum;
    logic signed [ACC_W-1:0]       w_mac;
    logic signed [ACC_W-1:0]       w_shr;
    logic signed [ACC_W-1:0]       w_relu;
    logic [ACC_W-DATA_W:0]         w_hi;
    logic                          w_fits;
    logic signed [DATA_W-1:0]      w_node_val;

    assign w_consume    = r_coef_req && coef_valid;
    assign w_last_input = r_layer2 ? (r_input == c_IN_W'(L1_SIZE - 1))
                                   : (r_input == c_IN_W'(L0_SIZE - 1));
    assign w_last_node  = r_layer2 ? (r_node == c_NODE_W'(L2_SIZE - 1))
                                   : (r_node == c_NODE_W'(L1_SIZE - 1));

    assign w_act  = r_layer2 ? r_l1_buf[r_input[c_L1_AW-1:0]]
                             : r_l0_buf[r_input[c_L0_AW-1:0]];
    assign w_prod = c_PROD_W'(w_act) * c_PROD_W'(coef_data);
    assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod);
    assign w_mac  = (w_sum[ACC_W] != w_sum[ACC_W-1])
                    ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX)
                    : w_sum[ACC_W-1:0];

    // Node activation is taken from the final accumulate so results can be registered in WRITE.
    assign w_shr      = w_mac >>> SHIFT;
    assign w_relu     = (!r_layer2 && w_shr[ACC_W-1]) ? '0 : w_shr;
    assign w_hi       = w_relu[ACC_W-1:DATA_W-1];
    assign w_fits     = (&w_hi) | ~(|w_hi);
    assign w_node_val = w_fits ? w_relu[DATA_W-1:0]
                               : (w_relu[ACC_W-1] ? c_OUT_MIN : c_OUT_MAX);

    always_ff @(posedge clk) begin
        if (!rst && r_state == c_ST_IDLE && act_wr_en) begin
            r_l0_buf[act_wr_addr] <= act_wr_data;
        end
        if (!rst && r_state == c_ST_MAC && w_consume && w_last_input && !r_layer2) begin
            r_l1_buf[r_node[c_L1_AW-1:0]] <= w_node_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_layer2    <= 1'b0;
            r_node      <= '0;
            r_input     <= '0;
            r_acc       <= '0;
            r_coef_req  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state    <= c_ST_BIAS;
                        r_layer2   <= 1'b0;
                        r_node     <= '0;
                        r_input    <= '0;
                        r_busy     <= 1'b1;
                        r_coef_req <= 1'b1;
                    end
                end
                c_ST_BIAS: begin
                    if (w_consume) begin
                        r_acc   <= ACC_W'(coef_data);
                        r_state <= c_ST_MAC;
                    end
                end
                c_ST_MAC: begin
                    if (w_consume) begin
                        r_acc <= w_mac;
                        if (w_last_input) begin
                            r_state    <= c_ST_WRITE;
                            r_coef_req <= 1'b0;
                            if (r_layer2) begin
                                r_out_valid <= 1'b1;
                                r_out_index <= c_OI_W'(r_node);
                                r_out_data  <= w_node_val;
                            end
                        end else begin
                            r_input <= r_input + 1'b1;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_input <= '0;
                    if (w_last_node && r_layer2) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= c_ST_BIAS;
                        r_coef_req <= 1'b1;
                        if (w_last_node) begin
                            r_layer2 <= 1'b1;
                            r_node   <= '0;
                        end else begin
                            r_node <= r_node + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign coef_req        = r_coef_req;
    assign busy            = r_busy;
    assign out_valid       = r_out_valid;
    assign out_index       = r_out_index;
    assign out_data        = r_out_data;
    assign done_processing = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ann_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ann_layer_engine                                             |
// | Purpose  : Self-checking bench for ann_layer_engine against an arithmetic  |
// |            reference model of the two-layer network.                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ann_layer_engine;

    localparam int c_L0 = 16;
    localparam int c_L1 = 4;
    localparam int c_L2 = 1;
    localparam int c_ACC_W = 24;
    localparam int c_SHIFT = 0;
    localparam int c_NCOEF = c_L1 * (c_L0 + 1) + c_L2 * (c_L1 + 1);
    localparam int c_L2_BASE = c_L1 * (c_L0 + 1);
    localparam int c_EXP_DONE = 1 + c_L1 * (c_L0 + 2) + c_L2 * (c_L1 + 2);

    logic              clk;
    logic              rst;
    logic              start;
    logic              act_wr_en;
    logic [3:0]        act_wr_addr;
    logic signed [7:0] act_wr_data;
    logic              coef_req;
    logic              coef_valid;
    logic signed [7:0] coef_data;
    logic              busy;
    logic              out_valid;
    logic [0:0]        out_index;
    logic signed [7:0] out_data;
    logic              done_processing;

    ann_layer_engine dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .act_wr_en       (act_wr_en),
        .act_wr_addr     (act_wr_addr),
        .act_wr_data     (act_wr_data),
        .coef_req        (coef_req),
        .coef_valid      (coef_valid),
        .coef_data       (coef_data),
        .busy            (busy),
        .out_valid       (out_valid),
        .out_index       (out_index),
        .out_data        (out_data),
        .done_processing (done_processing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    int act_v  [c_L0];
    int coef_v [c_NCOEF];

    int res_valid_cnt, res_valid_cyc, res_out_data, res_out_index;
    int res_done_cnt, res_done_cyc, res_consumed, res_stall_drop;
    int res_busy_after, res_timeout, res_rst_busy, res_rst_req, res_rst_data;

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int activate(input longint acc, input bit relu);
        longint v;
        v = acc >>> c_SHIFT;
        if (relu && v < 0) v = 0;
        return int'(clamp(v, -128, 127));
    endfunction

    // Reference: plain dot products with accumulator clamped after every add.
    function automatic int model_out();
        longint acc_lo, acc_hi, acc;
        int hid [c_L1];
        int k;
        acc_hi = (longint'(1) << (c_ACC_W - 1)) - 1;
        acc_lo = -(longint'(1) << (c_ACC_W - 1));
        k = 0;
        for (int j = 0; j < c_L1; j++) begin
            acc = coef_v[k]; k++;
            for (int i = 0; i < c_L0; i++) begin
                acc = clamp(acc + longint'(act_v[i]) * coef_v[k], acc_lo, acc_hi); k++;
            end
            hid[j] = activate(acc, 1'b1);
        end
        acc = coef_v[k]; k++;
        for (int i = 0; i < c_L1; i++) begin
            acc = clamp(acc + longint'(hid[i]) * coef_v[k], acc_lo, acc_hi); k++;
        end
        return activate(acc, 1'b0);
    endfunction

    task automatic set_layer1(input int bias, input int weight);
        for (int j = 0; j < c_L1; j++) begin
            coef_v[j * (c_L0 + 1)] = bias;
            for (int i = 0; i < c_L0; i++) coef_v[j * (c_L0 + 1) + 1 + i] = weight;
        end
    endtask

    task automatic set_layer2(input int bias, input int weight);
        coef_v[c_L2_BASE] = bias;
        for (int i = 0; i < c_L1; i++) coef_v[c_L2_BASE + 1 + i] = weight;
    endtask

    task automatic load_acts();
        for (int i = 0; i < c_L0; i++) begin
            @(negedge clk);
            act_wr_en   = 1'b1;
            act_wr_addr = 4'(i);
            act_wr_data = 8'(act_v[i]);
        end
        @(negedge clk);
        act_wr_en = 1'b0;
    endtask

    // valid_mode: 0 always valid, 1 toggle, 2 random. inject: 0 none, 1 start/act_wr while busy, 2 rst at cycle 40.
    task automatic run_inference(input int valid_mode, input int inject);
        int idx;
        bit prev_stall;
        bit finished;
        idx = 0; prev_stall = 1'b0; finished = 1'b0;
        res_valid_cnt = 0; res_valid_cyc = -1; res_out_data = 0; res_out_index = 0;
        res_done_cnt = 0; res_done_cyc = -1; res_stall_drop = 0; res_busy_after = -1;
        res_timeout = 0; res_rst_busy = -1; res_rst_req = -1; res_rst_data = -1;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                if (out_valid) begin
                    res_valid_cnt++; res_valid_cyc = cyc;
                    res_out_data = out_data; res_out_index = int'(out_index);
                end
                if (prev_stall && !coef_req) res_stall_drop++;
                if (res_done_cnt > 0 && cyc == res_done_cyc + 1) begin
                    res_busy_after = busy; finished = 1'b1;
                end
                if (done_processing) begin res_done_cnt++; res_done_cyc = cyc; end
                if (inject == 2 && cyc == 41) begin
                    res_rst_busy = busy; res_rst_req = coef_req; res_rst_data = out_data;
                end
                if (inject == 2 && cyc == 60) finished = 1'b1;
            end
            start       = (cyc == 0) || (inject == 1 && cyc == 20);
            act_wr_en   = (inject == 1 && cyc == 30);
            act_wr_addr = 4'd0;
            act_wr_data = 8'sd0;
            rst         = (inject == 2 && cyc == 40);
            case (valid_mode)
                0: coef_valid = 1'b1;
                1: coef_valid = (cyc % 2) == 0;
                default: coef_valid = $urandom_range(0, 3) != 0;
            endcase
            coef_data  = (idx < c_NCOEF) ? 8'(coef_v[idx]) : 8'sd0;
            prev_stall = coef_req && !coef_valid && !rst;
            if (coef_req && coef_valid && !rst) idx++;
        end
        if (!finished) res_timeout = 1;
        res_consumed = idx;
        start = 1'b0; act_wr_en = 1'b0; rst = 1'b0; coef_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (coef_req !== 1'b0) begin n_fail++; $display("FAIL reset coef_req: got %0b expected 0", coef_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %0b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (done_processing !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0b expected 0", done_processing); end
        n_checks++; if (out_data !== 8'sd0) begin n_fail++; $display("FAIL reset out_data: got %0d expected 0", out_data); end
        n_checks++; if (out_index !== 1'b0) begin n_fail++; $display("FAIL reset out_index: got %0d expected 0", out_index); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = 1;
        set_layer1(1, 1); set_layer2(1, 1);
        exp = model_out();
        load_acts();
        run_inference(0, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL ones out_data: got %0d expected %0d", res_out_data, exp); end
        n_checks++; if (res_out_index !== 0) begin n_fail++; $display("FAIL ones out_index: got %0d expected 0", res_out_index); end
        n_checks++; if (res_valid_cnt !== 1) begin n_fail++; $display("FAIL ones valid_count: got %0d expected 1", res_valid_cnt); end
        n_checks++; if (res_valid_cyc !== c_EXP_DONE - 1) begin n_fail++; $display("FAIL ones valid_cycle: got %0d expected %0d", res_valid_cyc, c_EXP_DONE - 1); end
        n_checks++; if (res_done_cyc !== c_EXP_DONE) begin n_fail++; $display("FAIL ones done_cycle: got %0d expected %0d", res_done_cyc, c_EXP_DONE); end
        n_checks++; if (res_done_cnt !== 1) begin n_fail++; $display("FAIL ones done_count: got %0d expected 1", res_done_cnt); end
        n_checks++; if (res_consumed !== c_NCOEF) begin n_fail++; $display("FAIL ones consumed: got %0d expected %0d", res_consumed, c_NCOEF); end
        n_checks++; if (res_busy_after !== 0) begin n_fail++; $display("FAIL ones busy_after_done: got %0d expected 0", res_busy_after); end
        repeat (3) @(negedge clk);
        n_checks++; if (out_data !== 8'(exp)) begin n_fail++; $display("FAIL ones out_data_hold: got %0d expected %0d", out_data, exp); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones valid_after: got %0b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = 127;
        set_layer1(0, 127); set_layer2(0, 127);
        exp = model_out();
        load_acts();
        run_inference(0, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL sat out_data: got %0d expected %0d", res_out_data, exp); end
        n_checks++; if (res_done_cnt !== 1) begin n_fail++; $display("FAIL sat done_count: got %0d expected 1", res_done_cnt); end
    endtask

    task automatic test_relu();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = $urandom_range(0, 255) - 128;
        load_acts();
        set_layer1(-100, 0); set_layer2(5, 1);
        exp = model_out();
        run_inference(0, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL relu_pos out_data: got %0d expected %0d", res_out_data, exp); end
        set_layer2(-5, 1);
        exp = model_out();
        run_inference(0, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL relu_neg out_data: got %0d expected %0d", res_out_data, exp); end
    endtask

    task automatic test_stall();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = 1;
        set_layer1(1, 1); set_layer2(1, 1);
        exp = model_out();
        load_acts();
        run_inference(1, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL stall out_data: got %0d expected %0d", res_out_data, exp); end
        n_checks++; if (res_stall_drop !== 0) begin n_fail++; $display("FAIL stall coef_req_drop: got %0d expected 0", res_stall_drop); end
        n_checks++; if (res_consumed !== c_NCOEF) begin n_fail++; $display("FAIL stall consumed: got %0d expected %0d", res_consumed, c_NCOEF); end
        n_checks++; if (!(res_done_cyc > c_EXP_DONE) || res_timeout != 0) begin n_fail++; $display("FAIL stall done_cycle: got %0d expected later than %0d", res_done_cyc, c_EXP_DONE); end
    endtask

    task automatic test_ignored_inputs();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = 1;
        set_layer1(1, 1); set_layer2(1, 1);
        exp = model_out();
        load_acts();
        run_inference(0, 1);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL ignored out_data: got %0d expected %0d", res_out_data, exp); end
        n_checks++; if (res_done_cnt !== 1) begin n_fail++; $display("FAIL ignored done_count: got %0d expected 1", res_done_cnt); end
        n_checks++; if (res_done_cyc !== c_EXP_DONE) begin n_fail++; $display("FAIL ignored done_cycle: got %0d expected %0d", res_done_cyc, c_EXP_DONE); end
    endtask

    task automatic test_reset_mid();
        int exp;
        for (int i = 0; i < c_L0; i++) act_v[i] = 1;
        set_layer1(1, 1); set_layer2(1, 1);
        exp = model_out();
        load_acts();
        run_inference(0, 2);
        n_checks++; if (res_rst_busy !== 0) begin n_fail++; $display("FAIL rst_mid busy: got %0d expected 0", res_rst_busy); end
        n_checks++; if (res_rst_req !== 0) begin n_fail++; $display("FAIL rst_mid coef_req: got %0d expected 0", res_rst_req); end
        n_checks++; if (res_rst_data !== 0) begin n_fail++; $display("FAIL rst_mid out_data: got %0d expected 0", res_rst_data); end
        n_checks++; if (res_valid_cnt !== 0) begin n_fail++; $display("FAIL rst_mid valid_count: got %0d expected 0", res_valid_cnt); end
        n_checks++; if (res_done_cnt !== 0) begin n_fail++; $display("FAIL rst_mid done_count: got %0d expected 0", res_done_cnt); end
        run_inference(0, 0);
        n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL rst_fresh out_data: got %0d expected %0d", res_out_data, exp); end
        n_checks++; if (res_valid_cyc !== c_EXP_DONE - 1) begin n_fail++; $display("FAIL rst_fresh valid_cycle: got %0d expected %0d", res_valid_cyc, c_EXP_DONE - 1); end
    endtask

    task automatic test_random();
        int exp;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < c_L0; i++) act_v[i] = $urandom_range(0, 255) - 128;
            for (int k = 0; k < c_NCOEF; k++) coef_v[k] = $urandom_range(0, 255) - 128;
            exp = model_out();
            load_acts();
            run_inference(2, 0);
            n_checks++; if (res_out_data !== exp) begin n_fail++; $display("FAIL random[%0d] out_data: got %0d expected %0d", t, res_out_data, exp); end
            n_checks++; if (res_valid_cnt !== 1 || res_done_cnt !== 1) begin n_fail++; $display("FAIL random[%0d] pulses: got valid=%0d done=%0d expected 1/1", t, res_valid_cnt, res_done_cnt); end
            n_checks++; if (res_consumed !== c_NCOEF) begin n_fail++; $display("FAIL random[%0d] consumed: got %0d expected %0d", t, res_consumed, c_NCOEF); end
            n_checks++; if (res_stall_drop !== 0) begin n_fail++; $display("FAIL random[%0d] coef_req_drop: got %0d expected 0", t, res_stall_drop); end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; act_wr_en = 1'b0; act_wr_addr = 4'd0;
        act_wr_data = 8'sd0; coef_valid = 1'b0; coef_data = 8'sd0;
        for (int k = 0; k < c_NCOEF; k++) coef_v[k] = 0;
        test_reset();
        test_all_ones();
        test_saturation();
        test_relu();
        test_stall();
        test_ignored_inputs();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ann_layer_engine.md
Name: ann_layer_engine

Overview:
- Parametrised two-weighted-layer MLP engine (L0 -> L1 -> L2) built around one serial MAC; generalises the fixed 16-4-1 ANN top.
- Holds the image activations in an internal buffer. Streams biases and weights over a valid/req handshake. Applies a shift, ReLU on the hidden layer, and saturation.
- Emits each output-layer node result serially, then pulses done_processing.
- Sits between the image/coefficient loader and the seven-segment/result logic.

Parameters:
DATA_W, 8, signed activation/result width
COEF_W, 8, signed bias/weight width
ACC_W, 24, signed accumulator width (>= DATA_W+COEF_W+clog2(L0_SIZE+1))
L0_SIZE, 16, input-layer node count
L1_SIZE, 4, hidden-layer node count
L2_SIZE, 1, output-layer node count
SHIFT, 0, arithmetic right shift applied to accumulator before activation

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to run one inference
act_wr_en  in  1  write strobe into L0 activation buffer
act_wr_addr  in  clog2(L0_SIZE)  L0 buffer index
act_wr_data  in  DATA_W  signed activation
coef_req  out  1  engine wants next coefficient
coef_valid  in  1  coefficient present on coef_data
coef_data  in  COEF_W  signed bias/weight
busy  out  1  high from accepted start through DONE inclusive
out_valid  out  1  one-cycle pulse per output-layer node
out_index  out  clog2(L2_SIZE)+1  output node index
out_data  out  DATA_W  signed output node value
done_processing  out  1  one-cycle pulse at end of inference

Behaviour:
- Reset: FSM=IDLE. coef_req, busy, out_valid, done_processing, out_index, out_data, accumulator and counters all = 0. Buffer contents are not cleared.
- FSM states: IDLE, BIAS, MAC, WRITE, DONE.
- IDLE: start=1 -> BIAS next cycle; layer=1, node=0, input=0. act_wr_en is honoured only in IDLE; it is ignored while busy.
- A coefficient is consumed in any cycle with coef_req && coef_valid. coef_req=1 exactly in BIAS and MAC. No consumption leaves state and counters unchanged.
- Coefficient order: layer 1 first, then layer 2. Within a layer, per node j ascending: bias, then weights w[j][0..N-1], where N = L0_SIZE for layer 1 and L1_SIZE for layer 2.
- BIAS, on consume: acc <= sign-extended bias; -> MAC.
- MAC, on consume: acc <= sat(acc + act[input]*coef). The product is a full-width signed multiply. The add saturates at the ACC_W signed limits. act comes from the L0 buffer (layer 1) or the L1 buffer (layer 2). On the last input -> WRITE; else input++.
- WRITE (one cycle): v = acc >>> SHIFT; layer 1 applies ReLU (v<0 -> 0); then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Layer 1 writes v into L1 buffer[node].
  - Layer 2 drives out_valid=1, out_index=node, out_data=v for that cycle.
  - Last node of layer 1 -> layer=2, node=0, BIAS. Last node of layer 2 -> DONE. Otherwise node++, input=0, BIAS.
- DONE (one cycle): done_processing=1, busy=1 -> IDLE.
- start while busy: ignored, no effect.
- rst mid-operation: returns to IDLE on the next edge, no out_valid/done pulse, and any partial accumulation is discarded.
- Latency with coef_valid held 1, start sampled at edge 0: BIAS in cycle 1. Each node takes N+2 cycles.
  - Defaults: layer 1 occupies cycles 1-72, layer 2 cycles 73-78, with out_valid in cycle 78 and done_processing in cycle 79.
  - Total coefficients consumed: L1*(L0+1) + L2*(L1+1) = 73.
- out_data/out_index hold their value after the pulse until the next WRITE in layer 2 or rst.

Test Plan:
- All 16 activations=1, all coefs=1, SHIFT=0, coef_valid=1 -> hidden nodes=17, one out_valid with out_index=0, out_data=69; done_processing in cycle 79 after start; 73 coefs consumed.
- Activations=127, weights=127, biases=0 -> hidden nodes saturate to 127, out_data saturates to 127; accumulator does not wrap.
- Layer-1 biases=-100, weights=0; layer-2 bias=5, weights=1 -> hidden ReLU gives 0, out_data=5. Layer-2 bias=-5 -> out_data=-5 (no ReLU on output).
- Vector from the first scenario with coef_valid toggling 1/0 every cycle -> identical out_data=69; coef_req stays high while stalled; done arrives later with still exactly 73 consumptions.
- start pulsed again at cycle 20, and act_wr_en writing 0 at cycle 30 -> both ignored; result still 69 with a single done pulse.
- rst asserted at cycle 40 -> next cycle busy=0 and coef_req=0, no out_valid/done. A fresh start then yields out_data=69 at the nominal timing.
